// File: rtl/sent_tx_channel.sv
// SENT transmitter channel: accepts a per-channel configuration and streams
// SYNC/STATUS/DATA/CRC(/PAUSE) frames back to back on the sent_out line.
module sent_tx_channel #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int CHANNEL_ID   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sent_config_vld,
  input  logic [7:0]  sent_config_channel,
  input  logic [7:0]  sent_ctick_len,
  input  logic [7:0]  sent_ltick_len,
  input  logic [1:0]  sent_pause_mode,
  input  logic [15:0] sent_pause_len,
  input  logic        sent_crc_mode,
  input  logic [3:0]  sent_status_nibble,
  input  logic [2:0]  sent_data_len,
  input  logic [23:0] sent_data_nibble,
  output logic        sent_out,
  output logic        sent_busy,
  output logic        sent_frame_done,
  output logic        sent_cfg_err
);

  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ_MHZ - 1);
  localparam logic [16:0] SYNC_TICKS   = 17'd56;
  localparam logic [16:0] VAR_FRAME    = 17'd270;
  localparam logic [16:0] MIN_PAUSE    = 17'd12;
  localparam logic [7:0]  MY_CHANNEL   = 8'(CHANNEL_ID);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_STATUS, S_DATA, S_CRC, S_PAUSE} state_t;

  typedef struct packed {
    logic [7:0]  ctick;
    logic [7:0]  ltick;
    logic [1:0]  pause_mode;
    logic [15:0] pause_len;
    logic        crc_mode;
    logic [3:0]  status;
    logic [2:0]  data_len;
    logic [23:0] data;
  } cfg_t;

  cfg_t        cfg_in;
  cfg_t        pend_reg;
  cfg_t        act_reg;
  logic        pend_vld_reg;
  state_t      state_reg;
  logic [PW-1:0] presc_reg;
  logic [7:0]  tick_reg;
  logic [16:0] sym_tick_reg;
  logic [16:0] sym_len_reg;
  logic [16:0] frame_ticks_reg;
  logic [2:0]  nib_idx_reg;
  logic [3:0]  crc_reg;
  logic        sent_out_reg;
  logic        busy_reg;
  logic        frame_done_reg;
  logic        cfg_err_reg;

  logic        cfg_hit;
  logic        cfg_ok;
  logic        presc_wrap;
  logic        tick_end;
  logic        sym_last;
  logic        frame_end;
  logic [16:0] frame_total;
  logic [16:0] pause_raw;
  logic [16:0] pause_ticks;
  logic [3:0]  nib [8];

  function automatic logic [16:0] nib_len(input logic [3:0] v);
    return 17'd12 + {13'd0, v};
  endfunction

  // CRC-4 over the data nibbles (MSB first), plus one zero nibble in recommended mode
  function automatic logic [3:0] crc4(input logic [23:0] data, input logic [2:0] len,
                                      input logic rec);
    logic [3:0]  c;
    logic [23:0] d;
    logic        b;
    logic        fb;
    c = 4'b0101;
    d = data;
    for (int i = 0; i < 7; i++) begin
      if ((i < int'(len)) || (rec && (i == int'(len)))) begin
        for (int j = 0; j < 4; j++) begin
          b  = (i < int'(len)) ? d[23] : 1'b0;
          fb = c[3] ^ b;
          c  = {c[2:0], 1'b0};
          if (fb) c = c ^ 4'b1101;
          d  = d << 1;
        end
      end
    end
    return c;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    if (gi < 6) begin : g_data
      assign nib[gi] = act_reg.data[23 - 4*gi -: 4];
    end else begin : g_pad
      assign nib[gi] = 4'd0;
    end
  end

  assign cfg_in = '{ctick: sent_ctick_len, ltick: sent_ltick_len,
                    pause_mode: sent_pause_mode, pause_len: sent_pause_len,
                    crc_mode: sent_crc_mode, status: sent_status_nibble,
                    data_len: sent_data_len, data: sent_data_nibble};

  always_comb begin
    cfg_hit    = sent_config_vld && (sent_config_channel == MY_CHANNEL);
    cfg_ok     = (sent_ctick_len >= 8'd3) && (sent_ctick_len <= 8'd90) &&
                 (sent_ltick_len >= 8'd4) &&
                 (sent_data_len != 3'd0) && (sent_data_len != 3'd7);
    presc_wrap = (presc_reg == PRESC_MAX);
    tick_end   = presc_wrap && (tick_reg == act_reg.ctick - 8'd1);
    sym_last   = tick_end && (sym_tick_reg == sym_len_reg - 17'd1);
    // Only meaningful in CRC: ticks from the start of SYNC through the end of CRC
    frame_total = frame_ticks_reg + sym_len_reg;
    case (act_reg.pause_mode)
      2'd1:    pause_raw = {1'b0, act_reg.pause_len};
      2'd2:    pause_raw = VAR_FRAME + {1'b0, act_reg.pause_len} - frame_total;
      default: pause_raw = 17'd0;
    endcase
    pause_ticks = pause_raw;
    if ((act_reg.pause_mode == 2'd1 || act_reg.pause_mode == 2'd2) && (pause_raw < MIN_PAUSE))
      pause_ticks = MIN_PAUSE;
    frame_end = sym_last && ((state_reg == S_PAUSE) ||
                             ((state_reg == S_CRC) && (pause_ticks == 17'd0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_hit && !cfg_ok;
      if (cfg_hit && cfg_ok) begin
        pend_reg     <= cfg_in;
        pend_vld_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      act_reg         <= '0;
      presc_reg       <= '0;
      tick_reg        <= '0;
      sym_tick_reg    <= '0;
      sym_len_reg     <= '0;
      frame_ticks_reg <= '0;
      nib_idx_reg     <= '0;
      crc_reg         <= '0;
      sent_out_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      crc_reg        <= crc4(act_reg.data, act_reg.data_len, act_reg.crc_mode);
      if (state_reg == S_IDLE) begin
        if (pend_vld_reg) begin
          act_reg         <= pend_reg;
          state_reg       <= S_SYNC;
          busy_reg        <= 1'b1;
          sent_out_reg    <= 1'b0;
          sym_len_reg     <= SYNC_TICKS;
          frame_ticks_reg <= '0;
          presc_reg       <= '0;
          tick_reg        <= '0;
          sym_tick_reg    <= '0;
        end
      end else begin
        presc_reg <= presc_wrap ? '0 : presc_reg + PW'(1);
        if (presc_wrap) tick_reg <= tick_end ? 8'd0 : tick_reg + 8'd1;
        if (tick_end && !sym_last) begin
          sym_tick_reg <= sym_tick_reg + 17'd1;
          sent_out_reg <= (sym_tick_reg + 17'd1) >= {9'd0, act_reg.ltick};
        end
        if (sym_last) begin
          sym_tick_reg <= '0;
          sent_out_reg <= 1'b0;
          case (state_reg)
            S_SYNC: begin
              state_reg       <= S_STATUS;
              sym_len_reg     <= nib_len(act_reg.status);
              frame_ticks_reg <= frame_total;
            end
            S_STATUS: begin
              state_reg       <= S_DATA;
              nib_idx_reg     <= '0;
              sym_len_reg     <= nib_len(nib[0]);
              frame_ticks_reg <= frame_total;
            end
            S_DATA: begin
              frame_ticks_reg <= frame_total;
              if (nib_idx_reg == act_reg.data_len - 3'd1) begin
                state_reg   <= S_CRC;
                sym_len_reg <= nib_len(crc_reg);
              end else begin
                nib_idx_reg <= nib_idx_reg + 3'd1;
                sym_len_reg <= nib_len(nib[nib_idx_reg + 3'd1]);
              end
            end
            S_CRC: begin
              if (pause_ticks != 17'd0) begin
                state_reg   <= S_PAUSE;
                sym_len_reg <= pause_ticks;
              end
            end
            default: ;
          endcase
        end
        // Frame boundary: the only place a pending configuration becomes active.
        // frame_done is registered, so it is high in the first cycle of the next SYNC.
        if (frame_end) begin
          state_reg       <= S_SYNC;
          act_reg         <= pend_reg;
          sym_len_reg     <= SYNC_TICKS;
          frame_ticks_reg <= '0;
          frame_done_reg  <= 1'b1;
          presc_reg       <= '0;
          tick_reg        <= '0;
        end
      end
    end
  end

  assign sent_out        = sent_out_reg;
  assign sent_busy       = busy_reg;
  assign sent_frame_done = frame_done_reg;
  assign sent_cfg_err    = cfg_err_reg;

endmodule

// File: doc/sent_tx_channel.md
SENT_TX_CHANNEL -- requirements
Module: sent_tx_channel

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 100, meaning clk cycles per microsecond.
REQ-002 Parameter CHANNEL_ID, default 0, meaning the 8-bit channel index this instance accepts.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sent_config_vld  input  1  one-cycle configuration strobe.
REQ-006 sent_config_channel  input  8  target channel index.
REQ-007 sent_ctick_len  input  8  tick length in us; 3..90 valid.
REQ-008 sent_ltick_len  input  8  low-pulse length in ticks; at least 4 valid.
REQ-009 sent_pause_mode  input  2  pause mode: 0 none, 1 fixed, 2 variable, 3 treated as 0.
REQ-010 sent_pause_len  input  16  pause length in ticks.
REQ-011 sent_crc_mode  input  1  CRC mode: 0 legacy, 1 recommended.
REQ-012 sent_status_nibble  input  4  status/communication nibble.
REQ-013 sent_data_len  input  3  data nibble count; 1..6 valid.
REQ-014 sent_data_nibble  input  24  data nibbles; [23:20] is nibble1 and is sent first.
REQ-015 sent_out  output  1  SENT line; idles high.
REQ-016 sent_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-017 sent_frame_done  output  1  one-cycle pulse at the end of each frame, including its pause.
REQ-018 sent_cfg_err  output  1  one-cycle pulse when a configuration addressed to this channel is rejected.

Function
REQ-019 Accept a configuration only when sent_config_vld=1 and sent_config_channel==CHANNEL_ID; ignore configurations for other channels.
REQ-020 Reject the configuration and pulse sent_cfg_err on the next cycle when any of these hold:
  - sent_ctick_len < 3 or > 90
  - sent_ltick_len < 4
  - sent_data_len is 0 or 7
  A rejected configuration leaves the stored configuration unchanged.
REQ-021 Store each accepted configuration in a pending register, one cycle after the strobe.
REQ-022 Copy the pending register into the active register only in IDLE or at a frame boundary, so a frame never changes parameters mid-transmission.
REQ-023 Tick generator: a 1 us prescaler counts CLK_FREQ_MHZ cycles; a tick counter counts ctick_len prescaler wraps.
REQ-024 Reset both prescaler and tick counter at the start of every frame.
REQ-025 FSM states: IDLE, SYNC, STATUS, DATA, CRC, PAUSE.
REQ-026 IDLE -> SYNC when a valid configuration is pending. SYNC -> STATUS -> DATA (data_len nibbles) -> CRC.
REQ-027 After CRC: go to PAUSE if the pause length is non-zero, else to SYNC. PAUSE -> SYNC.
REQ-028 The FSM never returns to IDLE except through reset; frames repeat continuously once configured.
REQ-029 Symbol lengths: SYNC is 56 ticks; a nibble of value v is 12+v ticks.
REQ-030 Every SYNC/STATUS/DATA/CRC symbol drives sent_out low for its first ltick_len ticks, then high for the rest of the symbol.
REQ-031 Pause pulse: ltick_len ticks low, then high.
REQ-032 Pause length by mode:
  - mode 0: 0 ticks
  - mode 1: pause_len ticks
  - mode 2: (270 + pause_len) - frame_ticks, where frame_ticks counts SYNC through CRC
  - a mode 1 or 2 result below 12 is forced to 12
  Arithmetic is 17-bit unsigned.
REQ-033 CRC-4 bitwise algorithm:
  - seed 4'b0101, polynomial x^4+x^3+x^2+1 (feedback mask 4'b1101)
  - per input bit b, MSB first: fb = crc[3]^b; crc = {crc[2:0],1'b0}; if fb, crc ^= 4'b1101
  - covers data nibbles only; the status nibble is excluded
  - recommended mode additionally shifts one 4'b0000 nibble after the data
REQ-034 Compute the CRC from the active register before the CRC symbol begins.
REQ-035 Timing:
  - accepted strobe at cycle N: pending loaded at N+1
  - if in IDLE, sent_out falls at N+2
  - sent_frame_done pulses in the cycle the last PAUSE tick (or last CRC tick when there is no pause) ends
REQ-036 Back-to-back accepted strobes: the last one wins.
REQ-037 When an accepted strobe and a frame boundary fall in the same cycle, the boundary loads the previous pending value; the new value applies at the following boundary.

Reset
REQ-038 While rst_n=0, asynchronously set:
  - sent_out=1
  - sent_busy=0, sent_frame_done=0, sent_cfg_err=0
  - FSM=IDLE, counters=0
  - pending and active configurations invalid and zero
REQ-039 Reset asserted mid-frame aborts the frame immediately.
REQ-040 After reset releases, no frame is sent until a new accepted configuration arrives.

Verification
REQ-041 Scenario, basic frame:
  - stimulus: CLK_FREQ_MHZ=10, CHANNEL_ID=2; config ch=2, ctick=3, ltick=4, data_len=1, data=0x0xxxxx, status=0, crc_mode=0, pause_mode=0
  - response: sync is 120 clk low then 1560 clk high; status nibble is 360 clk; CRC nibble value 3 is 450 clk; frames repeat
REQ-042 Scenario, recommended CRC: same stimulus with crc_mode=1 -> CRC nibble value 0xA (22 ticks).
REQ-043 Scenario, variable pause: data_len=6, all nibbles 0, pause_mode=2, pause_len=0:
  - frame_ticks = 56 + 12 + 72 + CRC ticks
  - pause = 270 - frame_ticks; each frame totals 270 ticks
REQ-044 Scenario, filtering: config with ch=5, or with ctick=2 -> no output change; the ctick=2 case with ch=2 pulses sent_cfg_err once.
REQ-045 Scenario, mid-frame update: a new config during the DATA state -> the current frame completes unchanged and the next sync uses the new ctick.
REQ-046 Scenario, reset mid-frame: rst_n low during DATA -> sent_out=1 in the same cycle; no output until reconfigured.
